swap_sched: RTL and testbench
=============================

SWAP_SCHED -- requirements
Module: swap_sched

Interface
REQ-001 The block SHALL have no parameters; register count is 4 (R1..R4) with R4 reserved as swap scratch.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req  input  [1:2]  per-requester command request; held high until granted.
REQ-005 Op1, Op2  input  1 each  command type: 0 = external load into Ra, 1 = swap Ra/Rb.
REQ-006 A1, B1, A2, B2  input  [1:0] each  register indices; 0..2 select R1..R3, 3 is illegal.
REQ-007 Gnt  output  [1:2]  one-hot grant; high for exactly one cycle when a command is accepted.
REQ-008 Rin  output  [1:4]  one-hot register load enables to the shared-bus datapath.
REQ-009 Rout  output  [1:4]  one-hot register bus-drive enables.
REQ-010 Extern  output  1  drives external Data onto the bus.
REQ-011 Busy  output  1  high in every non-IDLE state.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Err  output  1  qualifies Done; high only with Done for an illegal command.

Function
REQ-014 States SHALL be IDLE, LOAD, T1, T2, T3, FIN.
REQ-015 In IDLE with any Req high, Gnt SHALL go high combinationally for the selected requester, and its Op/A/B SHALL be latched on that rising edge.
REQ-016 Arbitration SHALL be round-robin: on a single request, grant it; on both requests, grant the requester not granted most recently.
REQ-017 The priority pointer SHALL update only on a grant.
REQ-018 Gnt SHALL be 0 in every state other than IDLE, and Req SHALL be ignored outside IDLE.
REQ-019 Load (Op=0, A<3): the next state SHALL be LOAD, driving Extern=1 and Rin[A+1]=1 for one cycle; the B index is ignored.
REQ-020 Swap (Op=1, A<3, B<3, A!=B): the FSM SHALL sequence three states.
REQ-021 T1: Rout[A+1]=1, Rin[4]=1.
REQ-022 T2: Rout[B+1]=1, Rin[A+1]=1.
REQ-023 T3: Rout[4]=1, Rin[B+1]=1.
REQ-024 At most one Rout bit or Extern SHALL be high in any cycle (no bus contention).
REQ-025 Rin and Rout SHALL be 0 in IDLE and FIN.
REQ-026 After LOAD or T3, the next state SHALL be FIN with Done=1 for one cycle; FIN SHALL then go to IDLE.
REQ-027 Swap with A==B (both legal) SHALL go from IDLE directly to FIN: no bus activity, Done=1, Err=0.
REQ-028 Any used index equal to 3 SHALL go from IDLE directly to FIN with no bus activity, Done=1, Err=1.
REQ-029 Latency from grant edge: load SHALL give Done 2 cycles later; swap 4 cycles; no-op/illegal 1 cycle.
REQ-030 The earliest next grant SHALL be in the IDLE cycle following FIN.
REQ-031 Rin, Rout, Extern, Busy, Done and Err SHALL be decoded from registered state and latched command only; Gnt is the only Mealy output.

Reset
REQ-032 While Reset=1 at a rising edge, the state SHALL go to IDLE, the latched command SHALL clear, and the pointer SHALL favour requester 1.
REQ-033 While Reset=1, every output SHALL be 0, including Gnt, regardless of Req.
REQ-034 Reset mid-operation (any state) SHALL abort the sequence with no Done pulse.

Verification
REQ-035 Bench: Req=2'b10, Op1=1, A1=0, B1=2 -> Gnt=10; then T1 Rout=1000/Rin=0001; T2 Rout=0010/Rin=1000; T3 Rout=0001/Rin=0010; FIN Done=1, Err=0.
REQ-036 Bench: Req=2'b01, Op2=0, A2=1 -> Gnt=01; next cycle Extern=1, Rin=0100, Rout=0000; following cycle Done=1.
REQ-037 Bench: Req=2'b11 held through three commands after reset -> grants in order 10, 01, 10.
REQ-038 Bench: Op1=1, A1=1, B1=1 -> Done one cycle after grant, Err=0, Rin/Rout=0 throughout; then A1=3 -> Done with Err=1.
REQ-039 Bench: Reset=1 during T2 of a swap -> next cycle IDLE, all outputs 0, no Done; the pending Req is then granted to requester 1 first.
REQ-040 Bench: every cycle of all scenarios -> Rout and Extern together have at most one bit set.

Source files
------------

// File: rtl/swap_sched_if.sv
// -----------------------------------------------------------------------------
// swap_sched_if
// Bundles the requester command inputs and the datapath/status outputs of the
// swap scheduler.
//   master : requester/bench side (drives req/op/index, observes the rest)
//   slave  : scheduler side
// Signals
//   req[1:2]          per-requester request, held until granted
//   op1, op2          0 = external load into Ra, 1 = swap Ra/Rb
//   a1,b1,a2,b2       register indices (0..2 -> R1..R3, 3 illegal)
//   gnt[1:2]          one-hot grant (combinational, IDLE only)
//   rin[1:4]          register load enables
//   rout[1:4]         register bus-drive enables
//   ext               external data drives the bus
//   busy, done, err   status; err qualifies done
// -----------------------------------------------------------------------------
interface swap_sched_if;
   logic [1:2] req;
   logic       op1;
   logic       op2;
   logic [1:0] a1;
   logic [1:0] b1;
   logic [1:0] a2;
   logic [1:0] b2;
   logic [1:2] gnt;
   logic [1:4] rin;
   logic [1:4] rout;
   logic       ext;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output req, op1, op2, a1, b1, a2, b2,
      input  gnt, rin, rout, ext, busy, done, err
   );

   modport slave (
      input  req, op1, op2, a1, b1, a2, b2,
      output gnt, rin, rout, ext, busy, done, err
   );
endinterface

// File: rtl/swap_sched.sv
// -----------------------------------------------------------------------------
// swap_sched
// Two-requester command scheduler for a shared-bus register file R1..R4.
// Accepts one command at a time (round-robin between requesters) and
// sequences the bus enables for either an external load into Ra or a
// three-step swap of Ra/Rb through scratch register R4.
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : swap_sched_if.slave (requests/commands in, enables/status out)
// All outputs except gnt are registered and change only with the state.
// -----------------------------------------------------------------------------
module swap_sched (
   input  logic         clk,
   input  logic         rst,
   swap_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      T1   = 3'd2,
      T2   = 3'd3,
      T3   = 3'd4,
      FIN  = 3'd5
   } state_t;

   state_t     state_r;
   logic       pref2_r;      // 1: requester 2 wins a tie next time
   logic [1:0] a_r;
   logic [1:0] b_r;
   logic [1:4] rin_r;
   logic [1:4] rout_r;
   logic       ext_r;
   logic       busy_r;
   logic       done_r;
   logic       err_r;

   logic       sel2_s;
   logic [1:2] gnt_s;
   logic       sel_op_s;
   logic [1:0] sel_a_s;
   logic [1:0] sel_b_s;
   logic       illegal_s;

   // Register index 0..2 to one-hot enable for R1..R3; 3 maps to nothing.
   function automatic logic [1:4] reg_sel(input logic [1:0] idx);
      logic [1:4] v;
      case (idx)
         2'd0:    v = 4'b1000;
         2'd1:    v = 4'b0100;
         2'd2:    v = 4'b0010;
         default: v = 4'b0000;
      endcase
      return v;
   endfunction

   // Round-robin pick and the Mealy grant, gated to IDLE and out of reset.
   always_comb begin
      sel2_s = bus.req[2] && (!bus.req[1] || pref2_r);
      if ((state_r == IDLE) && !rst) begin
         gnt_s = {bus.req[1] && !sel2_s, sel2_s};
      end else begin
         gnt_s = 2'b00;
      end
   end

   // Command of the requester being granted; only meaningful when gnt_s != 0.
   always_comb begin
      if (sel2_s) begin
         sel_op_s = bus.op2;
         sel_a_s  = bus.a2;
         sel_b_s  = bus.b2;
      end else begin
         sel_op_s = bus.op1;
         sel_a_s  = bus.a1;
         sel_b_s  = bus.b1;
      end
      // B is only looked at for swaps.
      illegal_s = (sel_a_s == 2'd3) || (sel_op_s && (sel_b_s == 2'd3));
   end

   // Scheduler FSM; outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         pref2_r <= 1'b0;
         a_r     <= 2'd0;
         b_r     <= 2'd0;
         rin_r   <= 4'b0000;
         rout_r  <= 4'b0000;
         ext_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (gnt_s != 2'b00) begin
                  // Pointer moves only on a grant: favour the other requester.
                  pref2_r <= gnt_s[1];
                  a_r     <= sel_a_s;
                  b_r     <= sel_b_s;
                  busy_r  <= 1'b1;
                  if (illegal_s) begin
                     state_r <= FIN;
                     done_r  <= 1'b1;
                     err_r   <= 1'b1;
                  end else if (!sel_op_s) begin
                     state_r <= LOAD;
                     ext_r   <= 1'b1;
                     rin_r   <= reg_sel(sel_a_s);
                  end else if (sel_a_s == sel_b_s) begin
                     // Swapping a register with itself is a no-op.
                     state_r <= FIN;
                     done_r  <= 1'b1;
                     err_r   <= 1'b0;
                  end else begin
                     state_r <= T1;
                     rout_r  <= reg_sel(sel_a_s);
                     rin_r   <= 4'b0001;
                  end
               end else begin
                  state_r <= IDLE;
                  rin_r   <= 4'b0000;
                  rout_r  <= 4'b0000;
                  ext_r   <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
                  err_r   <= 1'b0;
               end
            end
            LOAD: begin
               state_r <= FIN;
               ext_r   <= 1'b0;
               rin_r   <= 4'b0000;
               done_r  <= 1'b1;
               err_r   <= 1'b0;
            end
            T1: begin
               // Ra <- Rb
               state_r <= T2;
               rout_r  <= reg_sel(b_r);
               rin_r   <= reg_sel(a_r);
            end
            T2: begin
               // Rb <- R4 (old Ra)
               state_r <= T3;
               rout_r  <= 4'b0001;
               rin_r   <= reg_sel(b_r);
            end
            T3: begin
               state_r <= FIN;
               rout_r  <= 4'b0000;
               rin_r   <= 4'b0000;
               done_r  <= 1'b1;
               err_r   <= 1'b0;
            end
            FIN: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               err_r   <= 1'b0;
               rin_r   <= 4'b0000;
               rout_r  <= 4'b0000;
               ext_r   <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               err_r   <= 1'b0;
               rin_r   <= 4'b0000;
               rout_r  <= 4'b0000;
               ext_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_s;
   assign bus.rin  = rin_r;
   assign bus.rout = rout_r;
   assign bus.ext  = ext_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.err  = err_r;

endmodule

// File: tb/tb_swap_sched.sv
// -----------------------------------------------------------------------------
// tb_swap_sched
// Directed bench for swap_sched: swap, load, round-robin, no-op/illegal and
// reset-abort scenarios with hand-computed expected enables. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_swap_sched;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   swap_sched_if bus_if ();

   swap_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Next falling edge, plus the bus-contention check on every cycle.
   task automatic tick();
      @(negedge clk);
      chk("bus_onehot", {7'd0, ($countones({bus_if.rout, bus_if.ext}) <= 1)}, 8'd1);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_rin"},  {4'd0, bus_if.rin},  8'h00);
      chk({tag, "_rout"}, {4'd0, bus_if.rout}, 8'h00);
      chk({tag, "_stat"}, {4'd0, bus_if.ext, bus_if.busy, bus_if.done, bus_if.err}, 8'h00);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_if.req = 2'b11;
      bus_if.op1 = 1'b1; bus_if.a1 = 2'd0; bus_if.b1 = 2'd2;
      bus_if.op2 = 1'b0; bus_if.a2 = 2'd1; bus_if.b2 = 2'd0;
      @(posedge clk);
      @(posedge clk);
      tick();
      // Reset holds everything low, even with both requests up.
      chk("rst_gnt", {6'd0, bus_if.gnt}, 8'h00);
      chk_idle_outs("rst");

      // Swap R1/R3 from requester 1.
      rst = 1'b0;
      bus_if.req = 2'b10;
      #1 chk("swap_gnt", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      chk("t1_gnt", {6'd0, bus_if.gnt}, 8'h00);   // req still high, ignored
      bus_if.req = 2'b00;
      chk("t1_rout", {4'd0, bus_if.rout}, 8'h08);
      chk("t1_rin",  {4'd0, bus_if.rin},  8'h01);
      chk("t1_busy", {7'd0, bus_if.busy}, 8'h01);
      chk("t1_done", {7'd0, bus_if.done}, 8'h00);
      tick();
      chk("t2_rout", {4'd0, bus_if.rout}, 8'h02);
      chk("t2_rin",  {4'd0, bus_if.rin},  8'h08);
      tick();
      chk("t3_rout", {4'd0, bus_if.rout}, 8'h01);
      chk("t3_rin",  {4'd0, bus_if.rin},  8'h02);
      tick();
      chk("swfin_de", {6'd0, bus_if.done, bus_if.err}, 8'h02);
      chk("swfin_rin",  {4'd0, bus_if.rin},  8'h00);
      chk("swfin_rout", {4'd0, bus_if.rout}, 8'h00);
      tick();
      chk_idle_outs("sw_idle");

      // External load into R2 from requester 2 (B=3 ignored for loads).
      bus_if.req = 2'b01;
      bus_if.op2 = 1'b0; bus_if.a2 = 2'd1; bus_if.b2 = 2'd3;
      #1 chk("ld_gnt", {6'd0, bus_if.gnt}, 8'h01);
      tick();
      bus_if.req = 2'b00;
      chk("ld_ext",  {7'd0, bus_if.ext},  8'h01);
      chk("ld_rin",  {4'd0, bus_if.rin},  8'h04);
      chk("ld_rout", {4'd0, bus_if.rout}, 8'h00);
      chk("ld_done", {7'd0, bus_if.done}, 8'h00);
      tick();
      chk("ldfin_de", {6'd0, bus_if.done, bus_if.err}, 8'h02);
      chk("ldfin_ext", {7'd0, bus_if.ext}, 8'h00);
      tick();
      chk("ld_idle_busy", {7'd0, bus_if.busy}, 8'h00);

      // Round-robin with both requests held, starting fresh from reset.
      rst = 1'b1;
      tick();
      chk_idle_outs("rst2");
      rst = 1'b0;
      bus_if.req = 2'b11;
      bus_if.op1 = 1'b0; bus_if.a1 = 2'd0;
      bus_if.op2 = 1'b0; bus_if.a2 = 2'd2;
      #1 chk("rr_gnt1", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      chk("rr_ld1_rin", {4'd0, bus_if.rin}, 8'h08);
      tick();
      tick();
      #1 chk("rr_gnt2", {6'd0, bus_if.gnt}, 8'h01);
      tick();
      chk("rr_ld2_rin", {4'd0, bus_if.rin}, 8'h02);
      chk("rr_ld2_ext", {7'd0, bus_if.ext}, 8'h01);
      tick();
      tick();
      #1 chk("rr_gnt3", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      bus_if.req = 2'b00;
      tick();
      tick();

      // Swap of R2 with itself: one-cycle no-op completion.
      bus_if.req = 2'b10;
      bus_if.op1 = 1'b1; bus_if.a1 = 2'd1; bus_if.b1 = 2'd1;
      #1 chk("nop_gnt", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      bus_if.req = 2'b00;
      chk("nop_de",   {6'd0, bus_if.done, bus_if.err}, 8'h02);
      chk("nop_rin",  {4'd0, bus_if.rin},  8'h00);
      chk("nop_rout", {4'd0, bus_if.rout}, 8'h00);
      chk("nop_busy", {7'd0, bus_if.busy}, 8'h01);
      tick();
      chk_idle_outs("nop_idle");

      // Illegal A index on a load.
      bus_if.req = 2'b10;
      bus_if.op1 = 1'b0; bus_if.a1 = 2'd3;
      #1 chk("ilA_gnt", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      bus_if.req = 2'b00;
      chk("ilA_de",  {6'd0, bus_if.done, bus_if.err}, 8'h03);
      chk("ilA_bus", {3'd0, bus_if.ext, bus_if.rin}, 8'h00);
      tick();
      chk_idle_outs("ilA_idle");

      // Illegal B index on a swap from requester 2.
      bus_if.req = 2'b01;
      bus_if.op2 = 1'b1; bus_if.a2 = 2'd0; bus_if.b2 = 2'd3;
      #1 chk("ilB_gnt", {6'd0, bus_if.gnt}, 8'h01);
      tick();
      bus_if.req = 2'b00;
      chk("ilB_de",   {6'd0, bus_if.done, bus_if.err}, 8'h03);
      chk("ilB_rout", {4'd0, bus_if.rout}, 8'h00);
      tick();

      // Reset during T2 of a swap; requester 2 would otherwise be favoured.
      bus_if.req = 2'b10;
      bus_if.op1 = 1'b1; bus_if.a1 = 2'd2; bus_if.b1 = 2'd0;
      #1 chk("ab_gnt", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      chk("ab_t1_rout", {4'd0, bus_if.rout}, 8'h02);
      chk("ab_t1_rin",  {4'd0, bus_if.rin},  8'h01);
      bus_if.req = 2'b11;
      bus_if.op2 = 1'b0; bus_if.a2 = 2'd0;
      tick();
      chk("ab_t2_rout", {4'd0, bus_if.rout}, 8'h08);
      chk("ab_t2_rin",  {4'd0, bus_if.rin},  8'h02);
      rst = 1'b1;
      tick();
      chk("ab_rst_gnt", {6'd0, bus_if.gnt}, 8'h00);
      chk_idle_outs("ab_rst");
      rst = 1'b0;
      #1 chk("ab_regnt", {6'd0, bus_if.gnt}, 8'h02);
      tick();
      bus_if.req = 2'b00;
      chk("ab_re_rout", {4'd0, bus_if.rout}, 8'h02);
      chk("ab_re_done", {7'd0, bus_if.done}, 8'h00);
      tick();
      tick();
      tick();
      chk("ab_fin_de", {6'd0, bus_if.done, bus_if.err}, 8'h02);
      tick();
      chk_idle_outs("end_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
